// File: rtl/capture_if.sv
// Sample-RAM port and SPI read port of the capture controller.
// master: the controller side; slave: the RAM/SPI environment.
interface capture_if;
    logic        spi_req;
    logic [7:0]  spi_addr;
    logic        spi_ack;
    logic [11:0] spi_rdata;
    logic        ram_we;
    logic        ram_re;
    logic [6:0]  ram_addr;
    logic [23:0] ram_wdata;
    logic [23:0] ram_rdata;

    modport master (
        input  spi_req, spi_addr, ram_rdata,
        output spi_ack, spi_rdata, ram_we, ram_re, ram_addr, ram_wdata
    );

    modport slave (
        output spi_req, spi_addr, ram_rdata,
        input  spi_ack, spi_rdata, ram_we, ram_re, ram_addr, ram_wdata
    );
endinterface

// File: rtl/capture_ctrl.sv
// Captures the first and last 64 samples of a packet into a 128-entry RAM and serves SPI reads.
// Define CAPTURE_AUTO_REARM_EN to re-arm automatically after each completed capture.
module capture_ctrl #(
    parameter int PKT_LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [11:0]          I_in,
    input  logic [11:0]          Q_in,
    input  logic                 valid_data,
    input  logic [PKT_LEN_W-1:0] pkt_len,
    input  logic                 capture_start,
    capture_if.master            bus,
    output logic                 busy,
    output logic                 capture_done,
    output logic                 len_err
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_HEAD  = 3'd2;
    localparam logic [2:0] S_SKIP  = 3'd3;
    localparam logic [2:0] S_TAIL  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [PKT_LEN_W-1:0] MIN_LEN_C   = PKT_LEN_W'(8'd128);
    localparam logic [PKT_LEN_W-1:0] HALF_C      = PKT_LEN_W'(8'd64);
    localparam logic [PKT_LEN_W-1:0] HEAD_LAST_C = PKT_LEN_W'(8'd63);
    localparam logic [PKT_LEN_W-1:0] ONE_C       = PKT_LEN_W'(1'b1);
    localparam logic [PKT_LEN_W-1:0] ZERO_C      = PKT_LEN_W'(1'b0);

    logic [2:0]           state_q, state_d;
    logic [PKT_LEN_W-1:0] sample_count_q, sample_count_d;
    logic                 len_err_q, len_err_d;
    logic                 busy_q, done_q;
    logic                 ram_we_q, ram_re_q, spi_ack_q, rd_lsb_q;
    logic [6:0]           ram_addr_q;
    logic [23:0]          ram_wdata_q;

    logic                 store_s, rd_issue_s;
    logic [6:0]           store_addr_s, tail_addr_s;
    logic [PKT_LEN_W-1:0] last_idx_s, tail_start_s;

    assign last_idx_s   = pkt_len - ONE_C;
    assign tail_start_s = pkt_len - HALF_C;
    // Tail slots run 64..127, so modulo-128 arithmetic on the low bits is exact.
    assign tail_addr_s  = 7'd64 + sample_count_q[6:0] - tail_start_s[6:0];
    // A pending store owns the RAM port; one read in flight at a time.
    assign rd_issue_s   = bus.spi_req & ~store_s & ~ram_re_q;

    // Next-state logic: sample counter, capture FSM and store decision.
    always_comb begin
        state_d        = state_q;
        sample_count_d = sample_count_q;
        len_err_d      = len_err_q;
        store_s        = 1'b0;
        store_addr_s   = 7'd0;
        if (valid_data) begin
            if (sample_count_q >= last_idx_s) begin
                sample_count_d = ZERO_C;
            end else begin
                sample_count_d = sample_count_q + ONE_C;
            end
        end else begin
            sample_count_d = sample_count_q;
        end
        case (state_q)
            S_IDLE: begin
                if (capture_start) begin
                    if (pkt_len >= MIN_LEN_C) begin
                        state_d   = S_ARMED;
                        len_err_d = 1'b0;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARMED: begin
                if (valid_data && (sample_count_q == ZERO_C)) begin
                    store_s      = 1'b1;
                    store_addr_s = sample_count_q[6:0];
                    state_d      = S_HEAD;
                end else begin
                    state_d = S_ARMED;
                end
            end
            S_HEAD: begin
                if (valid_data) begin
                    store_s      = 1'b1;
                    store_addr_s = sample_count_q[6:0];
                    if (sample_count_q == HEAD_LAST_C) begin
                        state_d = (pkt_len == MIN_LEN_C) ? S_TAIL : S_SKIP;
                    end else begin
                        state_d = S_HEAD;
                    end
                end else begin
                    state_d = S_HEAD;
                end
            end
            S_SKIP: begin
                if (valid_data && (sample_count_q == tail_start_s)) begin
                    store_s      = 1'b1;
                    store_addr_s = tail_addr_s;
                    state_d      = S_TAIL;
                end else begin
                    state_d = S_SKIP;
                end
            end
            S_TAIL: begin
                if (valid_data) begin
                    store_s      = 1'b1;
                    store_addr_s = tail_addr_s;
                    state_d      = (sample_count_q == last_idx_s) ? S_DONE : S_TAIL;
                end else begin
                    state_d = S_TAIL;
                end
            end
            S_DONE: begin
`ifdef CAPTURE_AUTO_REARM_EN
                state_d = S_ARMED;
`else
                if (capture_start) begin
                    state_d = S_ARMED;
                end else begin
                    state_d = S_DONE;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, status flags and the registered RAM/SPI port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            sample_count_q <= ZERO_C;
            len_err_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_re_q       <= 1'b0;
            ram_addr_q     <= 7'd0;
            ram_wdata_q    <= 24'd0;
            spi_ack_q      <= 1'b0;
            rd_lsb_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_count_q <= sample_count_d;
            len_err_q      <= len_err_d;
            busy_q         <= (state_d == S_ARMED) || (state_d == S_HEAD) ||
                              (state_d == S_SKIP)  || (state_d == S_TAIL);
            done_q         <= (state_d == S_DONE);
            ram_we_q       <= store_s;
            ram_re_q       <= rd_issue_s;
            spi_ack_q      <= ram_re_q;
            if (store_s) begin
                ram_addr_q  <= store_addr_s;
                ram_wdata_q <= {I_in, Q_in};
            end else if (rd_issue_s) begin
                ram_addr_q  <= bus.spi_addr[7:1];
            end else begin
                ram_addr_q  <= ram_addr_q;
            end
            if (rd_issue_s) begin
                rd_lsb_q <= bus.spi_addr[0];
            end else begin
                rd_lsb_q <= rd_lsb_q;
            end
        end
    end

    assign busy          = busy_q;
    assign capture_done  = done_q;
    assign len_err       = len_err_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_re    = ram_re_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.spi_ack   = spi_ack_q;
    // RAM data arrives in the ack cycle; the half-word select was captured at issue.
    assign bus.spi_rdata = spi_ack_q ? (rd_lsb_q ? bus.ram_rdata[11:0] : bus.ram_rdata[23:12]) : 12'd0;
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter PKT_LEN_W, default 16, the width of pkt_len and sample_count.
REQ-002 SHALL have port clk, input, 1, the sample/upsampling clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports I_in and Q_in, input, 12 each, the filtered samples.
REQ-005 SHALL have port valid_data, input, 1, qualifying I_in/Q_in.
REQ-006 SHALL have port pkt_len, input, PKT_LEN_W, samples per packet; pkt_len is static while the FSM is not in IDLE.
REQ-007 SHALL have port capture_start, input, 1, a one-cycle pulse that arms capture.
REQ-008 SHALL have ports spi_req (input, 1) and spi_addr (input, 8), the SPI read request and address.
REQ-009 SHALL have ports spi_ack (output, 1) and spi_rdata (output, 12), the read completion pulse and data.
REQ-010 SHALL have ports ram_we, ram_re (output, 1 each), ram_addr (output, 7) and ram_wdata (output, 24, {I,Q}), the sample RAM port.
REQ-011 SHALL have port ram_rdata, input, 24, the RAM read data, valid one cycle after ram_re.
REQ-012 SHALL have ports busy, capture_done and len_err, output, 1 each, the status flags.

Function
REQ-013 SHALL keep sample_count: +1 per valid_data, wrapping from pkt_len-1 to 0.
REQ-014 SHALL implement FSM states IDLE, ARMED, HEAD, SKIP, TAIL and DONE.
REQ-015 IDLE SHALL move to ARMED on capture_start when pkt_len>=128; when pkt_len<128 it SHALL set len_err and stay in IDLE.
REQ-016 ARMED SHALL move to HEAD on the first valid_data sample with sample_count==0, and that sample SHALL be stored.
REQ-017 HEAD SHALL store samples 0..63 at addr=sample_count, then go to SKIP, or directly to TAIL if pkt_len==128.
REQ-018 SKIP SHALL discard samples and go to TAIL on the sample with sample_count==pkt_len-64, which SHALL be stored.
REQ-019 TAIL SHALL store at addr=64+sample_count-(pkt_len-64), then go to DONE after the sample at pkt_len-1.
REQ-020 DONE SHALL set capture_done and hold until capture_start, which clears capture_done and goes to ARMED.
REQ-021 capture_start in ARMED, HEAD, SKIP or TAIL SHALL be ignored.
REQ-022 busy SHALL be 1 in ARMED, HEAD, SKIP and TAIL.
REQ-023 A store SHALL be registered: ram_we=1 with ram_addr and ram_wdata={I_in,Q_in} one cycle after the valid_data sample.
REQ-024 Arbitration: a write SHALL always win; a read SHALL issue (ram_re=1, ram_addr=spi_addr[7:1]) only on a cycle with ram_we=0.
REQ-025 ram_we and ram_re SHALL never both be 1.
REQ-026 spi_ack SHALL pulse one cycle after ram_re, with spi_rdata = ram_rdata[23:12] when spi_addr[0]=0, else ram_rdata[11:0].
REQ-027 spi_req SHALL be held with stable spi_addr until spi_ack; at most one read SHALL be outstanding; spi_req sampled in the spi_ack cycle SHALL start a new read.
REQ-028 Reads SHALL be allowed in every state and return the current RAM contents.
REQ-029 len_err SHALL clear on the next capture_start with a legal pkt_len.

Reset
REQ-030 On rst low the block SHALL immediately force FSM=IDLE, sample_count=0, and all outputs to 0, including ram_we, ram_re, spi_ack, spi_rdata, capture_done, busy and len_err.
REQ-031 Reset mid-capture SHALL drop any pending write and read without issuing ack.
REQ-032 RAM contents are not cleared by reset.

Configuration
REQ-033 Macro CAPTURE_AUTO_REARM_EN SHALL select rearm behaviour: with it defined, DONE goes to ARMED on the next cycle, capture_done is a 1-cycle pulse and a capture_start pulse is needed only for the first arm; without it, REQ-020 applies.

Verification
REQ-034 pkt_len=512, capture_start, 512 continuous valid samples with I=n, Q=~n -> addr 0..63 hold n=0..63, addr 64..127 hold n=448..511, capture_done=1.
REQ-035 spi_req held through continuous valid_data -> no ram_re, no spi_ack; first idle cycle -> ram_re, spi_ack 1 cycle later; addr 0x83 after REQ-034 -> spi_rdata=~449[11:0].
REQ-036 pkt_len=100 with capture_start -> len_err=1, FSM stays IDLE, no ram_we.
REQ-037 pkt_len=128 -> HEAD goes directly to TAIL, writes to addr 0..127 in order, no SKIP.
REQ-038 rst low at sample 300 of REQ-034 -> outputs 0 the same cycle, no spi_ack; new capture_start after release -> normal capture.
REQ-039 capture_start issued mid-packet (sample_count=37) -> ARMED until sample_count wraps to 0, first write addr 0.
